// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Arbitrates one single-ported data memory between the pipeline
//            MEM stage (core port) and a debug/loader port (dbg port).
//            Exactly one access is in flight at a time; it is issued for one
//            cycle, waits MEM_LAT cycles for read data, then pulses done to
//            its owner.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   i_core_*       core request (req held until done), we, addr, wdata
//   o_core_rdata   last read data returned to the core
//   o_core_done    one-cycle completion pulse for the core
//   o_core_stall   pipeline stall: core_req & ~core_done
//   i_dbg_*/o_dbg_* same as core, for the debug port (no stall)
//   o_mem_*        memory strobe, write enable, address, write data
//   i_mem_rdata    memory read data, valid MEM_LAT cycles after o_mem_en
// ============================================================================
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,   // 1..7
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [DW-1:0] i_core_wdata,
  output logic [DW-1:0] o_core_rdata,
  output logic          o_core_done,
  output logic          o_core_stall,

  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_dbg_done,

  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] c_LAT        = 3'(MEM_LAT);
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  logic [1:0]    r_state;
  logic [1:0]    w_next;

  logic          r_owner;      // 0 = core, 1 = dbg
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_cnt;
  logic [3:0]    r_starve;
  logic [DW-1:0] r_core_rdata;
  logic [DW-1:0] r_dbg_rdata;

  logic          w_any_req;
  logic          w_both_req;
  logic          w_grant_dbg;
  logic          w_last_wait;

  logic          w_mem_en;
  logic          w_mem_we;
  logic          w_core_done;
  logic          w_dbg_done;

  assign w_any_req  = i_core_req | i_dbg_req;
  assign w_both_req = i_core_req & i_dbg_req;
  // dbg wins when alone, or when contested after STARVE_MAX core wins in a row
  assign w_grant_dbg = i_dbg_req & (~i_core_req | (r_starve == c_STARVE_MAX));
  // counter holds 1 in the cycle whose read data is valid; it hits 0 at this edge
  assign w_last_wait = (r_state == S_WAIT) && (r_cnt == 3'd1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_last_wait) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_core_done = 1'b0;
    w_dbg_done  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        w_mem_en = 1'b1;
        w_mem_we = r_we;
      end
      S_DONE: begin
        w_core_done = ~r_owner;
        w_dbg_done  = r_owner;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, latency counter, starvation counter, read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= 3'd0;
      r_starve     <= 4'd0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_dbg;
            r_we    <= w_grant_dbg ? i_dbg_we    : i_core_we;
            r_addr  <= w_grant_dbg ? i_dbg_addr  : i_core_addr;
            r_wdata <= w_grant_dbg ? i_dbg_wdata : i_core_wdata;
            if (w_grant_dbg) begin
              r_starve <= 4'd0;
            end else if (w_both_req && (r_starve != c_STARVE_MAX)) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= c_LAT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (w_last_wait && !r_we) begin
            if (r_owner) r_dbg_rdata  <= i_mem_rdata;
            else         r_core_rdata <= i_mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_en     = w_mem_en;
  assign o_mem_we     = w_mem_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_core_done  = w_core_done;
  assign o_dbg_done   = w_dbg_done;
  assign o_core_rdata = r_core_rdata;
  assign o_dbg_rdata  = r_dbg_rdata;
  assign o_core_stall = i_core_req & ~w_core_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A transaction-level model
//            predicts grants, issue/done cycles and returned data; a memory
//            model answers the DUT's accesses with data valid exactly
//            MEM_LAT cycles after the strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_done, core_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_done;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  // second instance for the single-cycle-latency build
  logic        l1_req = 1'b0;
  logic [31:0] l1_rdata_in = '0;
  logic [31:0] l1_core_rdata, l1_dbg_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_core_done, l1_core_stall, l1_dbg_done, l1_mem_en, l1_mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst(rst),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .o_core_rdata(core_rdata), .o_core_done(core_done),
    .o_core_stall(core_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata), .o_dbg_done(dbg_done),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .i_core_req(l1_req), .i_core_we(1'b0), .i_core_addr(32'h20),
    .i_core_wdata(32'h0), .o_core_rdata(l1_core_rdata), .o_core_done(l1_core_done),
    .o_core_stall(l1_core_stall),
    .i_dbg_req(1'b0), .i_dbg_we(1'b0), .i_dbg_addr(32'h0),
    .i_dbg_wdata(32'h0), .o_dbg_rdata(l1_dbg_rdata), .o_dbg_done(l1_dbg_done),
    .o_mem_en(l1_mem_en), .o_mem_we(l1_mem_we), .o_mem_addr(l1_mem_addr),
    .o_mem_wdata(l1_mem_wdata), .i_mem_rdata(l1_rdata_in)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // memory contents, word-indexed by addr[5:2]
  logic [31:0] tbmem [16];
  int          pend_cyc = -100;
  logic [31:0] pend_val = '0;

  // transaction-level model
  bit          m_active = 0;
  bit          m_owner  = 0;        // 0 core, 1 dbg
  bit          m_we     = 0;
  int          m_issue  = -100;
  int          m_done   = -100;
  logic [31:0] m_rdval  = '0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  int          m_streak = 0;        // contested core wins since dbg last won
  logic [31:0] e_crd = '0, e_drd = '0;
  bit          core_dropped = 0, dbg_dropped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_streak = 0;
    m_addr   = '0;
    m_wdata  = '0;
    e_crd    = '0;
    e_drd    = '0;
    pend_cyc = -100;
  endtask

  task automatic grant(input bit to_dbg);
    m_owner  = to_dbg;
    m_we     = to_dbg ? dbg_we : core_we;
    m_addr   = to_dbg ? dbg_addr : core_addr;
    m_wdata  = to_dbg ? dbg_wdata : core_wdata;
    m_issue  = cyc + 1;
    m_done   = cyc + MEM_LAT + 2;
    m_rdval  = tbmem[m_addr[5:2]];
    m_active = 1;
  endtask

  // one clock cycle: model reacts to the edge, then outputs are checked
  task automatic step();
    bit e_cdone, e_ddone, e_en;
    @(posedge clk);
    if (rst) begin
      if (m_active && cyc == m_done) begin
        m_active = 0;
      end else if (!m_active && (core_req || dbg_req)) begin
        if (core_req && dbg_req) begin
          if (m_streak >= STARVE_MAX) begin
            grant(1); m_streak = 0;
          end else begin
            grant(0); m_streak = m_streak + 1;
          end
        end else if (dbg_req) begin
          grant(1); m_streak = 0;
        end else begin
          grant(0);
        end
      end
    end
    cyc++;
    #1;
    // memory: writes land on the strobe, reads answer MEM_LAT cycles later
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr[5:2]] = mem_wdata;
      else begin
        pend_cyc = cyc + MEM_LAT;
        pend_val = tbmem[mem_addr[5:2]];
      end
    end
    mem_rdata = (cyc == pend_cyc) ? pend_val : $urandom;
    e_en    = m_active && (cyc == m_issue);
    e_cdone = m_active && (cyc == m_done) && !m_owner;
    e_ddone = m_active && (cyc == m_done) &&  m_owner;
    if (m_active && cyc == m_done && !m_we) begin
      if (m_owner) e_drd = m_rdval;
      else         e_crd = m_rdval;
    end
    chk("mem_en",     {31'b0, mem_en},     {31'b0, e_en});
    chk("mem_we",     {31'b0, mem_we},     {31'b0, e_en & m_we});
    chk("mem_addr",   mem_addr,            m_addr);
    chk("mem_wdata",  mem_wdata,           m_wdata);
    chk("core_done",  {31'b0, core_done},  {31'b0, e_cdone});
    chk("dbg_done",   {31'b0, dbg_done},   {31'b0, e_ddone});
    chk("core_rdata", core_rdata,          e_crd);
    chk("dbg_rdata",  dbg_rdata,           e_drd);
    chk("core_stall", {31'b0, core_stall}, {31'b0, core_req & ~e_cdone});
  endtask

  // random requester behaviour for one port, decided in the current cycle
  task automatic drive_port(input bit is_dbg, inout logic req, inout logic we,
                            inout logic [31:0] addr, inout logic [31:0] wdata,
                            inout bit dropped);
    bit done_now, in_flight;
    done_now  = m_active && (cyc == m_done) && (m_owner == is_dbg);
    in_flight = m_active && (m_owner == is_dbg) && (cyc >= m_issue) && !done_now;
    if (done_now) begin
      dropped = 0;
      req = ($urandom_range(0, 9) < 6);
      we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    end else if (req) begin
      if (in_flight && $urandom_range(0, 19) == 0) begin
        req = 0; dropped = 1;
      end
    end else if (!dropped && !in_flight && $urandom_range(0, 9) < 3) begin
      req = 1; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    end
  endtask

  initial begin : main
    int nwr;
    int ndone;
    int order[10];
    int when[10];
    for (int i = 0; i < 16; i++) tbmem[i] = $urandom;
    model_reset();

    // reset state
    step(); step();
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b1;
    step();

    // core read 0x0C -> 0xDEADBEEF
    tbmem[3] = 32'hDEADBEEF;
    core_req = 1; core_we = 0; core_addr = 32'h0C; core_wdata = 32'h77;
    #1 chk("rd_stall_c0", {31'b0, core_stall}, 32'd1);
    step();
    chk("rd_mem_en_c1", {31'b0, mem_en}, 32'd1);
    chk("rd_addr_c1", mem_addr, 32'h0C);
    step(); step();
    chk("rd_stall_c3", {31'b0, core_stall}, 32'd1);
    chk("rd_done_c3", {31'b0, core_done}, 32'd0);
    step();
    chk("rd_done_c4", {31'b0, core_done}, 32'd1);
    chk("rd_data_c4", core_rdata, 32'hDEADBEEF);
    chk("rd_stall_c4", {31'b0, core_stall}, 32'd0);
    core_req = 0;
    step();

    // core write 0x5 to 0x0C
    core_req = 1; core_we = 1; core_addr = 32'h0C; core_wdata = 32'h5;
    nwr = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (mem_en && mem_we) begin
        nwr++;
        chk("wr_addr", mem_addr, 32'h0C);
        chk("wr_data", mem_wdata, 32'h5);
      end
      if (i == 4) begin
        chk("wr_done_c4", {31'b0, core_done}, 32'd1);
        core_req = 0;
      end
    end
    chk("wr_strobes", nwr, 32'd1);
    chk("wr_rdata_kept", core_rdata, 32'hDEADBEEF);

    // dbg read 0x10 -> 0x12345678
    tbmem[4] = 32'h12345678;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("dbg_no_stall", {31'b0, core_stall}, 32'd0);
    end
    chk("dbg_done_c4", {31'b0, dbg_done}, 32'd1);
    chk("dbg_data", dbg_rdata, 32'h12345678);
    chk("dbg_core_kept", core_rdata, 32'hDEADBEEF);
    dbg_req = 0;
    step();

    // both requesting continuously: starvation relief every fifth grant
    core_req = 1; core_we = 0; core_addr = 32'h0C;
    dbg_req  = 1; dbg_we  = 0; dbg_addr  = 32'h10;
    ndone = 0;
    for (int i = 0; i < 80 && ndone < 10; i++) begin
      step();
      if (core_done && dbg_done) chk("both_done", 32'd1, 32'd0);
      if (core_done || dbg_done) begin
        order[ndone] = dbg_done ? 1 : 0;
        when[ndone]  = cyc;
        ndone++;
      end
    end
    core_req = 0; dbg_req = 0;
    chk("starve_ndone", ndone, 32'd10);
    for (int i = 0; i < ndone; i++) begin
      chk("starve_order", order[i], (i == 4 || i == 9) ? 32'd1 : 32'd0);
      if (i > 0) chk("starve_gap", when[i] - when[i-1], MEM_LAT + 3);
    end
    step(); step();

    // reset during WAIT, then re-arbitration of a held request
    core_req = 1; core_we = 0; core_addr = 32'h0C;
    step(); step();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("arst_done", {31'b0, core_done}, 32'd0);
    chk("arst_core_rdata", core_rdata, 32'h0);
    chk("arst_dbg_rdata", dbg_rdata, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("arst_reissue", {31'b0, mem_en}, 32'd1);
    chk("arst_addr", mem_addr, 32'h0C);
    step(); step(); step();
    chk("arst_done_after", {31'b0, core_done}, 32'd1);
    chk("arst_rdata", core_rdata, 32'h5);
    core_req = 0;
    step();

    // single-cycle-latency instance
    l1_req = 1; l1_rdata_in = 32'h0BAD0BAD;
    step();
    chk("l1_mem_en_c1", {31'b0, l1_mem_en}, 32'd1);
    step();
    chk("l1_done_c2", {31'b0, l1_core_done}, 32'd0);
    l1_rdata_in = 32'hCAFEF00D;
    step();
    chk("l1_done_c3", {31'b0, l1_core_done}, 32'd1);
    chk("l1_data_c3", l1_core_rdata, 32'hCAFEF00D);
    l1_rdata_in = 32'h0BAD0BAD; l1_req = 0;
    step();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      drive_port(0, core_req, core_we, core_addr, core_wdata, core_dropped);
      drive_port(1, dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_dropped);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
